// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC arithmetic blocks.
//   ATAN_TAB : atan(2^-i) in Q3.13 radians, indexed by micro-rotation i
//   PI/HALF_PI : Q3.13 radians
//   K_INV    : 1/K in Q2.14, used by the rotation-mode sin/cos generator
//   K_GAIN   : CORDIC gain K in Q2.14 LSBs (reference value)
//   state_t  : iterative engine control states
package cordic_pkg;

  localparam int ATAN_N = 16;

  localparam int ATAN_TAB [ATAN_N] = '{
    6434, 3798, 2007, 1019, 511, 256, 128, 64,
    32,   16,   8,    4,    2,   1,   0,   0
  };

  localparam int PI      = 25736;
  localparam int HALF_PI = 12868;

  localparam logic [15:0] K_INV  = 16'h26DD;
  localparam int          K_GAIN = 26981;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup for CORDIC micro-rotations.
//   idx  : micro-rotation index i (0..15)
//   atan : atan(2^-i) in Q3.13 radians, WIDTH bits signed
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       idx,
  output logic [WIDTH-1:0] atan
);

  assign atan = WIDTH'(ATAN_TAB[idx]);

endmodule

// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: (x, y) -> (K*|v|, atan2(y, x)).
// One shift-add micro-rotation per clock, with a quadrant pre-rotation so
// inputs in the left half-plane are folded onto the right before iterating.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : request, sampled only while idle
//   x_in, y_in   : signed Q2.14 operands, captured on an accepted start
//   busy         : high from the cycle after acceptance through the done cycle
//   done         : one-cycle pulse, mag/angle valid from this cycle onward
//   mag          : unsigned Q4.14 gain-scaled magnitude
//   angle        : signed Q3.13 radians in [-pi, +pi]
module cordic_vector
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH+1:0] mag,
  output logic [WIDTH-1:0] angle
);

  localparam int XW = WIDTH + 2;
  localparam int CW = 4;

  localparam logic signed [WIDTH-1:0] PI_W = WIDTH'(PI);

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic                    zero_p0;
  logic signed [XW-1:0]    x_p0;
  logic signed [XW-1:0]    y_p0;
  logic signed [WIDTH-1:0] z_p0;

  logic signed [XW-1:0]    x_ext;
  logic signed [XW-1:0]    y_ext;
  logic signed [XW-1:0]    xs;
  logic signed [XW-1:0]    ys;
  logic signed [XW-1:0]    x_nxt;
  logic signed [XW-1:0]    y_nxt;
  logic signed [WIDTH-1:0] z_nxt;
  logic [WIDTH-1:0]        atan_raw;
  logic signed [WIDTH-1:0] atan_i;

  // Two guard bits keep the negation of the most negative input exact.
  assign x_ext = {{2{x_in[WIDTH-1]}}, x_in};
  assign y_ext = {{2{y_in[WIDTH-1]}}, y_in};

  cordic_atan_rom #(
    .WIDTH (WIDTH)
  ) u_atan_rom (
    .idx  (cnt),
    .atan (atan_raw)
  );

  assign atan_i = atan_raw;
  assign xs     = x_p0 >>> cnt;
  assign ys     = y_p0 >>> cnt;

  // Drive Y toward zero; Z accumulates the angle rotated through.
  always_comb begin
    x_nxt = x_p0;
    y_nxt = y_p0;
    z_nxt = z_p0;
    if (!y_p0[XW-1]) begin
      x_nxt = x_p0 + ys;
      y_nxt = y_p0 - xs;
      z_nxt = z_p0 + atan_i;
    end else begin
      x_nxt = x_p0 - ys;
      y_nxt = y_p0 + xs;
      z_nxt = z_p0 - atan_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      mag     <= '0;
      angle   <= '0;
      cnt     <= '0;
      zero_p0 <= 1'b0;
      x_p0    <= '0;
      y_p0    <= '0;
      z_p0    <= '0;
    end else begin
      case (state)
        // Capture with pre-rotation: left half-plane vectors are negated
        // and Z starts at +/-pi depending on which side of the x axis.
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (x_in[WIDTH-1]) begin
              x_p0 <= -x_ext;
              y_p0 <= -y_ext;
              z_p0 <= y_in[WIDTH-1] ? -PI_W : PI_W;
            end else begin
              x_p0 <= x_ext;
              y_p0 <= y_ext;
              z_p0 <= '0;
            end
            zero_p0 <= (x_in == '0) && (y_in == '0);
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= ROTATE;
          end
        end

        // Micro-rotation stage; results land in the output registers on
        // the last iteration so they are valid together with done.
        ROTATE: begin
          x_p0 <= x_nxt;
          y_p0 <= y_nxt;
          z_p0 <= z_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) begin
            state <= DONE;
            done  <= 1'b1;
            mag   <= zero_p0 ? '0 : $unsigned(x_nxt);
            angle <= zero_p0 ? '0 : $unsigned(z_nxt);
          end
        end

        // Result cycle; start is not sampled here.
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vector.sv
// Directed-vector bench for cordic_vector: latency, quadrant handling,
// zero vector, start/done handshake and mid-operation reset.
module tb_cordic_vector;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] x_in;
  logic [15:0] y_in;
  logic        busy;
  logic        done;
  logic [17:0] mag;
  logic [15:0] angle;

  int checks   = 0;
  int failures = 0;

  cordic_vector #(
    .WIDTH (16),
    .ITER  (16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .x_in  (x_in),
    .y_in  (y_in),
    .busy  (busy),
    .done  (done),
    .mag   (mag),
    .angle (angle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp, input int tol);
    checks++;
    if ((got - exp > tol) || (exp - got > tol)) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d tol=%0d", tag, got, exp, tol);
    end
  endtask

  task automatic check_range(input string tag, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      failures++;
      $display("FAIL %s got=%0d exp=[%0d..%0d]", tag, got, lo, hi);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int ang();
    return int'($signed(angle));
  endfunction

  // Presents operands with start for one edge; returns sampled in cycle 1.
  task automatic launch(input logic [15:0] xv, input logic [15:0] yv);
    x_in  = xv;
    y_in  = yv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts cycles from acceptance (cycle 1 = first cycle after accept edge).
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  int lat;
  int mag_ref;
  int ang_ref;
  int ndone;
  int d1;
  int d2;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;
    repeat (3) tick();
    check("rst_busy", busy, 0, 0);
    check("rst_done", done, 0, 0);
    check("rst_mag", int'(mag), 0, 0);
    check("rst_angle", ang(), 0, 0);
    reset = 1'b0;
    tick();

    // Positive x axis.
    launch(16'h4000, 16'h0000);
    check("axis_busy_c1", busy, 1, 0);
    wait_done(lat);
    check("axis_latency", lat, 17, 0);
    check("axis_busy_done", busy, 1, 0);
    check("axis_angle", ang(), 0, 2);
    check("axis_mag", int'(mag), 26981, 4);
    tick();
    check("axis_done_width", done, 0, 0);
    check("axis_busy_after", busy, 0, 0);

    // Negative x axis folds to +pi.
    launch(16'hC000, 16'h0000);
    wait_done(lat);
    check("negx_latency", lat, 17, 0);
    check("negx_abs_angle", (ang() < 0) ? -ang() : ang(), 25736, 2);
    check("negx_mag", int'(mag), 26981, 6);
    tick();

    // Quadrant III, just below the negative x axis.
    launch(16'hC000, 16'hFF00);
    wait_done(lat);
    check_range("q3_angle", ang(), -25736, -25000);
    tick();

    // +90 and -90 degrees.
    launch(16'h0000, 16'h4000);
    wait_done(lat);
    check("pos90_angle", ang(), 12868, 2);
    tick();
    launch(16'h0000, 16'hC000);
    wait_done(lat);
    check("neg90_angle", ang(), -12868, 2);
    tick();

    // Most negative x: negation must be exact, magnitude K*2.0.
    launch(16'h8000, 16'h0000);
    wait_done(lat);
    check("xmin_abs_angle", (ang() < 0) ? -ang() : ang(), 25736, 2);
    check("xmin_mag", int'(mag), 53962, 10);
    tick();

    // Diagonal, 45 degrees.
    launch(16'h2D41, 16'h2D41);
    wait_done(lat);
    check("diag_angle", ang(), 6434, 2);
    check("diag_mag", int'(mag), 26981, 6);
    mag_ref = int'(mag);
    ang_ref = ang();
    tick();

    // Zero vector forces exact zeros.
    launch(16'h0000, 16'h0000);
    wait_done(lat);
    check("zero_latency", lat, 17, 0);
    check("zero_mag", int'(mag), 0, 0);
    check("zero_angle", ang(), 0, 0);
    tick();

    // A start pulse mid-rotation is ignored and does not queue.
    launch(16'h2D41, 16'h2D41);
    repeat (5) tick();
    x_in  = 16'hC000;
    y_in  = 16'h0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 7;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check("midstart_latency", lat, 17, 0);
    check("midstart_mag", int'(mag), mag_ref, 0);
    check("midstart_angle", ang(), ang_ref, 0);
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) ndone++;
    end
    check("midstart_no_queue", ndone, 0, 0);

    // start held high: one result per 18 cycles.
    x_in  = 16'h4000;
    y_in  = 16'h0000;
    start = 1'b1;
    ndone = 0;
    d1 = -1;
    d2 = -1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (done) begin
        ndone++;
        if (d1 < 0) d1 = n;
        else if (d2 < 0) d2 = n;
      end
    end
    start = 1'b0;
    check("held_first", d1, 17, 0);
    check("held_period", d2 - d1, 18, 0);
    check("held_count", ndone, 3, 0);
    repeat (20) tick();

    // Reset mid-rotation discards the operation.
    launch(16'h4000, 16'h0000);
    repeat (8) tick();
    reset = 1'b1;
    tick();
    check("midrst_busy", busy, 0, 0);
    check("midrst_done", done, 0, 0);
    check("midrst_mag", int'(mag), 0, 0);
    check("midrst_angle", ang(), 0, 0);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0, 0);
    launch(16'h0000, 16'h4000);
    wait_done(lat);
    check("postrst_latency", lat, 17, 0);
    check("postrst_angle", ang(), 12868, 2);
    check("postrst_mag", int'(mag), 26981, 6);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
